test_sequencer: RTL

//   Run controller for one arithmetic test pass. On i_start it clears the scoreboard,

---
 rtl/test_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/test_sequencer.sv
// ---------------------------------------------------------------------------
// test_sequencer
//
// Run controller for one arithmetic test pass. A start request clears the
// scoreboard, enables the stimulus generator for exactly i_num_vec cycles and
// follows each issued vector through the DUT pipeline. The scoreboard is
// unfrozen only on cycles that carry a valid DUT result. Once the pipeline
// has drained, a pass/fail verdict is latched from the scoreboard error
// counter.
//
// Parameters
//   LATENCY      DUT pipeline depth in cycles (>= 1)
//   CNT_W        width of the vector count and the issue counter
//
// Ports
//   clk          clock
//   reset        synchronous, active-high reset
//   i_start      start a pass (taken only in IDLE or DONE)
//   i_abort      abandon the current pass (beats i_start while busy)
//   i_num_vec    number of vectors to issue, latched on an accepted start
//   i_error_ctr  scoreboard error count
//   o_sb_reset   one-cycle scoreboard clear
//   o_gen_en     generator enable, one vector per high cycle
//   o_sb_freeze  scoreboard freeze, low only while a valid result is present
//   o_busy       high in CLEAR, RUN and DRAIN
//   o_done       high in DONE
//   o_pass       verdict, meaningful while o_done is high
//   o_state      IDLE=0 CLEAR=1 RUN=2 DRAIN=3 DONE=4
// ---------------------------------------------------------------------------
module test_sequencer #(
   parameter int LATENCY = 4,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [CNT_W-1:0] i_num_vec,
   input  logic [31:0]      i_error_ctr,
   output logic             o_sb_reset,
   output logic             o_gen_en,
   output logic             o_sb_freeze,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_pass,
   output logic [2:0]       o_state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t             state;
   state_t             next_state;
   logic [CNT_W-1:0]   n_reg;
   logic [CNT_W-1:0]   issue_ctr;
   logic [LATENCY-1:0] pipe;
   logic [LATENCY-1:0] pipe_next;
   logic               is_busy;
   logic               start_taken;
   logic               abort_taken;
   logic               last_issue;
   logic               pipe_empty;

   // Decodes shared by the FSM and the datapath. A start is only accepted when
   // no pass is in flight, and an abort only matters while one is. The last
   // issue is detected by comparing against n_reg-1 so that the counter never
   // has to reach a value beyond the largest legal vector count.
   assign is_busy     = (state == CLEAR) || (state == RUN) || (state == DRAIN);
   assign start_taken = i_start && ((state == IDLE) || (state == DONE));
   assign abort_taken = i_abort && is_busy;
   assign last_issue  = (issue_ctr == (n_reg - CNT_W'(1)));
   assign pipe_empty  = (pipe == '0);

   // The valid pipe shifts in the generator enable each cycle so that its top
   // bit marks the cycle on which that vector's result leaves the DUT. A
   // one-deep pipe simply registers the enable.
   generate
      if (LATENCY == 1) begin : g_pipe_single
         assign pipe_next = o_gen_en;
      end else begin : g_pipe_multi
         assign pipe_next = {pipe[LATENCY-2:0], o_gen_en};
      end
   endgenerate

   // State register: reset always returns to IDLE, even in the middle of a pass.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. Abort takes priority in every busy state. CLEAR skips
   // straight to DRAIN for an empty pass so the generator is never enabled.
   // DRAIN waits for every in-flight result to leave the pipe.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (i_start) begin
               next_state = CLEAR;
            end
         end
         CLEAR: begin
            if (i_abort) begin
               next_state = IDLE;
            end else if (n_reg != '0) begin
               next_state = RUN;
            end else begin
               next_state = DRAIN;
            end
         end
         RUN: begin
            if (i_abort) begin
               next_state = IDLE;
            end else if (last_issue) begin
               next_state = DRAIN;
            end
         end
         DRAIN: begin
            if (i_abort) begin
               next_state = IDLE;
            end else if (pipe_empty) begin
               next_state = DONE;
            end
         end
         DONE: begin
            if (i_start) begin
               next_state = CLEAR;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Pass datapath: vector count, issue counter, valid pipe and verdict.
   // The vector count is captured only on an accepted start so a mid-pass
   // change on i_num_vec has no effect. An abort flushes the pipe so the
   // scoreboard stays frozen for results of the abandoned pass. The verdict is
   // sampled on the cycle the pipe is seen empty, one cycle after the last
   // valid result, by which time the error counter has settled.
   always_ff @(posedge clk) begin
      if (reset) begin
         n_reg     <= '0;
         issue_ctr <= '0;
         pipe      <= '0;
         o_pass    <= 1'b0;
      end else begin
         if (abort_taken) begin
            pipe <= '0;
         end else begin
            pipe <= pipe_next;
         end

         if (start_taken) begin
            n_reg     <= i_num_vec;
            issue_ctr <= '0;
         end else if (state == RUN) begin
            issue_ctr <= issue_ctr + CNT_W'(1);
         end

         if (start_taken || abort_taken) begin
            o_pass <= 1'b0;
         end else if ((state == DRAIN) && pipe_empty) begin
            o_pass <= (i_error_ctr == 32'd0);
         end
      end
   end

   // Output decode. Everything except the verdict is a pure function of the
   // registered state and the registered valid pipe, so the outputs never
   // depend combinationally on the host inputs.
   always_comb begin
      o_sb_reset  = (state == CLEAR);
      o_gen_en    = (state == RUN);
      o_sb_freeze = ~pipe[LATENCY-1];
      o_busy      = is_busy;
      o_done      = (state == DONE);
      o_state     = state;
   end

endmodule
